// File: rtl/fetch_exc.sv
// Fetch-stage program counter with a three-state exception controller.
// Saves PC/cause on an exception, vectors to a handler, returns on ERet, and halts on a nested exception.
module fetch_exc #(
  parameter int unsigned  N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'(64'h0000_0000_0000_00D8)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_F,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  input  logic         Exc,
  input  logic [3:0]   ExcCode,
  input  logic         ERet,
  output logic [N-1:0] imem_addr_F,
  output logic [N-1:0] NextPC_F,
  output logic [N-1:0] EPC,
  output logic [3:0]   ESR,
  output logic         ExcActive,
  output logic         Halt
);

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t       r_state;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_epc;
  logic [3:0]   r_esr;
  logic         r_exc_active;
  logic         r_halt;
  logic [N-1:0] w_pc_plus4;
  logic [N-1:0] w_seq_pc;

  // Sequential PC wraps modulo 2^N; the carry is deliberately dropped.
  assign w_pc_plus4 = r_pc + PC_STEP;

  // Ordinary sequencing shared by NORMAL and HANDLER when no Exc/ERet acts.
  always_comb begin
    w_seq_pc = w_pc_plus4;
    if (stall_F)      w_seq_pc = r_pc;
    else if (PCSrc_F) w_seq_pc = PCBranch_F;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_NORMAL;
      r_pc         <= '0;
      r_epc        <= '0;
      r_esr        <= '0;
      r_exc_active <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      case (r_state)
        S_NORMAL: begin
          if (Exc) begin
            r_epc        <= r_pc;
            r_esr        <= ExcCode;
            r_pc         <= EXC_VECTOR;
            r_state      <= S_HANDLER;
            r_exc_active <= 1'b1;
          end else begin
            r_pc <= w_seq_pc;
          end
        end
        S_HANDLER: begin
          if (Exc) begin
            r_state      <= S_HALT;
            r_exc_active <= 1'b0;
            r_halt       <= 1'b1;
          end else if (ERet) begin
            r_pc         <= r_epc;
            r_state      <= S_NORMAL;
            r_exc_active <= 1'b0;
          end else begin
            r_pc <= w_seq_pc;
          end
        end
        S_HALT: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state      <= S_NORMAL;
          r_exc_active <= 1'b0;
          r_halt       <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr_F = r_pc;
  assign NextPC_F    = w_pc_plus4;
  assign EPC         = r_epc;
  assign ESR         = r_esr;
  assign ExcActive   = r_exc_active;
  assign Halt        = r_halt;

endmodule

// File: tb/tb_fetch_exc.sv
// Self-checking bench for fetch_exc: directed scenarios, then randomized traffic vs a behavioural model.
module tb_fetch_exc;

  localparam int unsigned  N   = 64;
  localparam logic [N-1:0] VEC = 64'h0000_0000_0000_00D8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall_F = 1'b0;
  logic         PCSrc_F = 1'b0;
  logic [N-1:0] PCBranch_F = '0;
  logic         Exc = 1'b0;
  logic [3:0]   ExcCode = '0;
  logic         ERet = 1'b0;
  logic [N-1:0] imem_addr_F;
  logic [N-1:0] NextPC_F;
  logic [N-1:0] EPC;
  logic [3:0]   ESR;
  logic         ExcActive;
  logic         Halt;

  fetch_exc #(.N(N), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .PCSrc_F(PCSrc_F),
    .PCBranch_F(PCBranch_F), .Exc(Exc), .ExcCode(ExcCode), .ERet(ERet),
    .imem_addr_F(imem_addr_F), .NextPC_F(NextPC_F), .EPC(EPC), .ESR(ESR),
    .ExcActive(ExcActive), .Halt(Halt)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC/EPC/ESR plus two mode flags.
  logic [N-1:0] m_pc, m_epc;
  logic [3:0]   m_esr;
  bit           m_in_handler, m_halted;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},   imem_addr_F,     m_pc);
    chk({tag, ".next"}, NextPC_F,        m_pc + 64'd4);
    chk({tag, ".epc"},  EPC,             m_epc);
    chk({tag, ".esr"},  N'(ESR),         N'(m_esr));
    chk({tag, ".exca"}, N'(ExcActive),   N'(m_in_handler));
    chk({tag, ".halt"}, N'(Halt),        N'(m_halted));
  endtask

  task automatic model_reset();
    m_pc = '0; m_epc = '0; m_esr = '0; m_in_handler = 0; m_halted = 0;
  endtask

  // Apply one rising edge to the model using the priority order of the fetch rules.
  task automatic model_edge();
    if (m_halted) return;
    if (Exc) begin
      if (m_in_handler) begin
        m_halted = 1; m_in_handler = 0;
      end else begin
        m_epc = m_pc; m_esr = ExcCode; m_pc = VEC; m_in_handler = 1;
      end
    end else if (ERet && m_in_handler) begin
      m_pc = m_epc; m_in_handler = 0;
    end else if (stall_F) begin
      m_pc = m_pc;
    end else if (PCSrc_F) begin
      m_pc = PCBranch_F;
    end else begin
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic drive(input bit st, input bit br, input logic [N-1:0] tgt,
                       input bit ex, input logic [3:0] code, input bit er);
    stall_F = st; PCSrc_F = br; PCBranch_F = tgt; Exc = ex; ExcCode = code; ERet = er;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset between edges: outputs must clear without any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".imm"});
    drive(1'b0, 1'b1, 64'h1234, 1'b1, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held across edges with busy inputs.
    drive(1'b1, 1'b1, 64'hABC, 1'b1, 4'h7, 1'b1);
    #2;
    check_all("rst0");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    check_all("rel");

    for (int i = 0; i < 3; i++) step($sformatf("seq%0d", i));

    drive(1'b0, 1'b1, 64'h10, 1'b0, '0, 1'b0);  step("to10");
    drive(1'b1, 1'b1, 64'h100, 1'b0, '0, 1'b0); step("br_stall");
    drive(1'b0, 1'b1, 64'h100, 1'b0, '0, 1'b0); step("br100");

    drive(1'b0, 1'b1, 64'h20, 1'b0, '0, 1'b0);  step("to20");
    drive(1'b1, 1'b1, 64'h300, 1'b1, 4'h3, 1'b0); step("exc");
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);      step("hdl_seq");
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);      step("eret");
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);      step("post_eret");

    drive(1'b0, 1'b0, '0, 1'b1, 4'hA, 1'b0);    step("exc2");
    drive(1'b0, 1'b0, '0, 1'b1, 4'h5, 1'b1);    step("to_halt");
    drive(1'b0, 1'b1, 64'h500, 1'b0, '0, 1'b1); step("halt_br");
    drive(1'b0, 1'b0, '0, 1'b1, 4'h1, 1'b0);    step("halt_exc");
    async_reset("rst_halt");
    step("after_rst");

    drive(1'b0, 1'b1, {N{1'b1}} - 64'd3, 1'b0, '0, 1'b0); step("to_top");
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);      step("wrap");
    drive(1'b0, 1'b1, 64'h40, 1'b0, '0, 1'b0);  step("to40");
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);      step("eret_normal");

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] tgt;
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) tgt = {N{1'b1}} - N'($urandom_range(0, 15));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, tgt,
            $urandom_range(0, 11) == 0, 4'($urandom), $urandom_range(0, 4) == 0);
      step($sformatf("rnd%0d", i));
      if ($urandom_range(0, 59) == 0) async_reset($sformatf("rnd_rst%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_exc.md
FETCH_EXC -- requirements
Module: fetch_exc

Interface
REQ-001 Parameter N, default 64, datapath and address width in bits.
REQ-002 Parameter EXC_VECTOR, default 64'h0000_0000_0000_00D8, exception handler entry address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 stall_F  input  1  high holds PC for this cycle.
REQ-006 PCSrc_F  input  1  high selects PCBranch_F as next PC.
REQ-007 PCBranch_F  input  N  branch target address.
REQ-008 Exc  input  1  exception request for the instruction at current PC.
REQ-009 ExcCode  input  4  cause code captured with Exc.
REQ-010 ERet  input  1  return-from-exception request.
REQ-011 imem_addr_F  output  N  current PC, drives instruction memory address.
REQ-012 NextPC_F  output  N  combinational PC+4 of current PC, forwarded for link/branch use.
REQ-013 EPC  output  N  saved PC of the excepting instruction.
REQ-014 ESR  output  4  saved cause code.
REQ-015 ExcActive  output  1  high while in HANDLER state.
REQ-016 Halt  output  1  high while in HALT state.

Function
REQ-017 State machine SHALL have three states: NORMAL, HANDLER, HALT.
REQ-018 NextPC_F SHALL equal imem_addr_F + 4 modulo 2^N, zero latency.
REQ-019 Next-PC priority per edge SHALL be: HALT hold > Exc > ERet > stall_F > PCSrc_F > PC+4.
REQ-020 NORMAL, Exc=1: EPC <= current PC, ESR <= ExcCode, PC <= EXC_VECTOR, state <= HANDLER, regardless of stall_F/PCSrc_F.
REQ-021 HANDLER, Exc=1: state <= HALT; PC, EPC, ESR unchanged.
REQ-022 HANDLER, ERet=1, Exc=0: PC <= EPC, state <= NORMAL; EPC, ESR unchanged; stall_F ignored.
REQ-023 NORMAL, ERet=1, Exc=0: ERet ignored; normal sequencing applies.
REQ-024 No Exc/ERet action: stall_F=1 holds PC; else PCSrc_F=1 loads PCBranch_F unmodified (low bits not masked); else PC <= PC+4.
REQ-025 HALT: PC, EPC, ESR, state frozen; all inputs ignored; exit only via reset.
REQ-026 ExcActive and Halt SHALL be registered state decodes, changing the cycle after the triggering edge.
REQ-027 PC+4 from 2^N-4 SHALL wrap to 0 with no flag.
REQ-028 EPC/ESR SHALL be written only by REQ-020.

Reset
REQ-029 reset=0 SHALL immediately, without a clock edge, force PC=0, EPC=0, ESR=0, state=NORMAL, ExcActive=0, Halt=0.
REQ-030 Reset asserted mid-handler or in HALT SHALL abandon that state; first edge after release fetches from 0 onward (PC 0 -> 4).
REQ-031 Outputs SHALL hold reset values while reset=0, irrespective of clock or other inputs.

Verification
REQ-032 Reset release, no inputs, 3 edges -> imem_addr_F 0,4,8,12; NextPC_F 4,8,12,16.
REQ-033 PC=0x10, PCSrc_F=1, PCBranch_F=0x100 -> PC=0x100; same with stall_F=1 -> PC stays 0x10.
REQ-034 PC=0x20, Exc=1, ExcCode=4'h3, stall_F=1 -> PC=0xD8, EPC=0x20, ESR=3, ExcActive=1; then ERet=1 -> PC=0x20, ExcActive=0, EPC still 0x20.
REQ-035 In HANDLER, Exc=1 and ERet=1 same cycle -> Halt=1, PC unchanged, EPC/ESR unchanged; later branches/ERet ignored; reset=0 between edges -> PC=0 immediately, Halt=0.
REQ-036 Force PC=2^N-4 via branch, one edge -> PC=0; ERet in NORMAL at PC=0x40 -> PC=0x44, EPC unchanged.
